// File: rtl/max_unpooling_2x2.sv
// Nearest-neighbour 2x upsampler: each raster input pixel becomes a 2x2 output block via a one-row replay buffer.
// First copy appears 1 cycle after accept. Ready drops for the second copy and the replayed row. No downstream backpressure.
module max_unpooling_2x2 #(
  parameter int DATA_WIDHT = 32,
  parameter int IMG_WIDHT  = 44,
  parameter int IMG_HEIGHT = 44
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDHT-1:0] Data_In,
  input  logic                  Valid_In,
  output logic                  Ready,
  output logic [DATA_WIDHT-1:0] Data_Out,
  output logic                  Valid_Out,
  output logic                  Frame_Done
);
  localparam int CW = (IMG_WIDHT > 1) ? $clog2(IMG_WIDHT) : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDHT - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  typedef enum logic {WRITE, REPLAY} state_t;

  state_t                state, state_nxt;
  logic                  phase, phase_nxt;
  logic [CW-1:0]         col, col_nxt;
  logic [RW-1:0]         row, row_nxt;
  logic [DATA_WIDHT-1:0] dat_nxt;
  logic                  vld_nxt;
  logic                  done_nxt;
  logic                  buf_we;
  logic [DATA_WIDHT-1:0] row_buf [IMG_WIDHT];

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= WRITE;
      phase      <= 1'b0;
      col        <= '0;
      row        <= '0;
      Data_Out   <= '0;
      Valid_Out  <= 1'b0;
      Frame_Done <= 1'b0;
    end else begin
      state      <= state_nxt;
      phase      <= phase_nxt;
      col        <= col_nxt;
      row        <= row_nxt;
      Data_Out   <= dat_nxt;
      Valid_Out  <= vld_nxt;
      Frame_Done <= done_nxt;
    end
  end

  // Row buffer is never cleared; a stale row is always overwritten before it is replayed.
  always_ff @(posedge clk) begin
    if (buf_we) begin
      row_buf[col] <= Data_In;
    end
  end

  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    col_nxt   = col;
    row_nxt   = row;
    dat_nxt   = Data_Out;
    vld_nxt   = 1'b0;
    done_nxt  = 1'b0;
    buf_we    = 1'b0;
    Ready     = 1'b0;
    case (state)
      WRITE: begin
        if (!phase) begin
          Ready = 1'b1;
          if (Valid_In) begin
            dat_nxt   = Data_In;
            vld_nxt   = 1'b1;
            buf_we    = 1'b1;
            phase_nxt = 1'b1;
          end
        end else begin
          // Second copy: Data_Out simply holds the captured pixel.
          vld_nxt   = 1'b1;
          phase_nxt = 1'b0;
          if (col == COL_LAST) begin
            col_nxt   = '0;
            state_nxt = REPLAY;
          end else begin
            col_nxt = col + CW'(1);
          end
        end
      end
      REPLAY: begin
        vld_nxt   = 1'b1;
        dat_nxt   = row_buf[col];
        phase_nxt = ~phase;
        if (phase) begin
          if (col == COL_LAST) begin
            col_nxt   = '0;
            state_nxt = WRITE;
            if (row == ROW_LAST) begin
              row_nxt  = '0;
              done_nxt = 1'b1;
            end else begin
              row_nxt = row + RW'(1);
            end
          end else begin
            col_nxt = col + CW'(1);
          end
        end
      end
      default: state_nxt = WRITE;
    endcase
  end
endmodule

// File: tb/tb_max_unpooling_2x2.sv
// Directed bench: a 4x2 instance for the stream/timing cases and a default 44x44 instance for the checkerboard frame.
module tb_max_unpooling_2x2;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data_in;
  logic        valid_in;
  logic        ready;
  logic [31:0] data_out;
  logic        valid_out;
  logic        frame_done;

  logic        big_en;
  logic        big_valid_in;
  logic [31:0] big_data_in;
  logic        big_ready;
  logic [31:0] big_data_out;
  logic        big_valid_out;
  logic        big_frame_done;
  int          px_idx;

  int          n_assert = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [31:0] q_dat[$];
  bit          q_done[$];
  bit          q_rdy[$];
  int          q_cyc[$];
  logic [31:0] b_dat[$];
  bit          b_done[$];

  always #5 clk = ~clk;

  max_unpooling_2x2 #(.DATA_WIDHT(32), .IMG_WIDHT(4), .IMG_HEIGHT(2)) dut (
    .clk(clk), .rst(rst), .Data_In(data_in), .Valid_In(valid_in), .Ready(ready),
    .Data_Out(data_out), .Valid_Out(valid_out), .Frame_Done(frame_done)
  );

  max_unpooling_2x2 dut_big (
    .clk(clk), .rst(rst), .Data_In(big_data_in), .Valid_In(big_valid_in), .Ready(big_ready),
    .Data_Out(big_data_out), .Valid_Out(big_valid_out), .Frame_Done(big_frame_done)
  );

  // Checkerboard source for the 44x44 instance, advanced on every accepted pixel.
  always_comb begin
    big_valid_in = big_en && (px_idx < 44 * 44);
    big_data_in  = (((px_idx / 44) + (px_idx % 44)) % 2 == 1) ? 32'hFFFFFFFF : 32'h00000000;
  end

  always @(posedge clk) begin
    if (rst) px_idx <= 0;
    else if (big_valid_in && big_ready) px_idx <= px_idx + 1;
  end

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (valid_out) begin
      q_dat.push_back(data_out);
      q_done.push_back(frame_done);
      q_rdy.push_back(ready);
      q_cyc.push_back(cyc);
    end
    if (big_valid_out) begin
      b_dat.push_back(big_data_out);
      b_done.push_back(big_frame_done);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    valid_in = 1'b0;
    repeat (n) begin
      data_in = $urandom;
      @(negedge clk);
    end
  endtask

  // Offer one pixel; while Ready is low, optionally drive junk on Data_In to prove it is ignored.
  task automatic send(input logic [31:0] d, input bit toggle);
    bit done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      valid_in = 1'b1;
      if (ready) begin
        data_in = d;
        @(negedge clk);
        done = 1'b1;
      end else begin
        data_in = toggle ? $urandom : d;
        @(negedge clk);
      end
    end
    valid_in = 1'b0;
    if (!done) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_beats(input string tag, input int n);
    for (int i = 0; i < 400 && q_dat.size() < n; i++) @(negedge clk);
    idle(3);
    chk({tag, "_beat_count"}, 32'(q_dat.size()), 32'(n));
  endtask

  task automatic clear_q();
    q_dat.delete();
    q_done.delete();
    q_rdy.delete();
    q_cyc.delete();
  endtask

  // 4x2 frame of consecutive pixels p0..p0+7: beat k carries input (row k/16, col (k%8)/2).
  task automatic check_frame(input string tag, input int p0);
    int nd = 0;
    for (int k = 0; k < 32 && k < q_dat.size(); k++) begin
      chk($sformatf("%s_val%0d", tag, k), q_dat[k], 32'(p0 + (k / 16) * 4 + (k % 8) / 2));
      if (q_done[k]) nd++;
    end
    chk({tag, "_done_count"}, 32'(nd), 32'd1);
    if (q_dat.size() >= 32) begin
      chk({tag, "_done_last"}, 32'(q_done[31]), 32'd1);
      for (int k = 0; k < 32; k += 2)
        chk($sformatf("%s_pair%0d", tag, k), 32'(q_cyc[k + 1] - q_cyc[k]), 32'd1);
    end
  endtask

  initial begin
    int bad;
    int nd;
    rst      = 1'b1;
    valid_in = 1'b0;
    data_in  = 32'd0;
    big_en   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_data_out", data_out, 32'd0);
    chk("rst_valid_out", 32'(valid_out), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_ready", 32'(ready), 32'd1);
    rst = 1'b0;

    // Back-to-back frame 1..8: no output bubbles anywhere.
    for (int p = 1; p <= 8; p++) send(32'(p), 1'b0);
    wait_beats("A", 32);
    check_frame("A", 1);
    if (q_dat.size() >= 32) begin
      for (int k = 0; k < 31; k++)
        chk($sformatf("A_nogap%0d", k), 32'(q_cyc[k + 1] - q_cyc[k]), 32'd1);
      chk("A_ready_last_write", 32'(q_rdy[7]), 32'd0);
      for (int k = 8; k < 15; k++)
        chk($sformatf("A_ready_replay%0d", k), 32'(q_rdy[k]), 32'd0);
      chk("A_ready_last_replay", 32'(q_rdy[15]), 32'd1);
      chk("A_ready_frame_end", 32'(q_rdy[31]), 32'd1);
    end
    clear_q();

    // Second frame with idle gap after pixel 12 and junk data while Ready is low.
    send(32'd11, 1'b1);
    send(32'd12, 1'b1);
    idle(3);
    for (int p = 13; p <= 18; p++) send(32'(p), 1'b1);
    wait_beats("B", 32);
    check_frame("B", 11);
    if (q_dat.size() >= 32)
      chk("B_gap_between_pairs", 32'(q_cyc[4] - q_cyc[3] > 1), 32'd1);
    clear_q();

    // Reset in the middle of the row replay.
    for (int p = 21; p <= 24; p++) send(32'(p), 1'b0);
    for (int i = 0; i < 100 && q_dat.size() < 11; i++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_valid_out", 32'(valid_out), 32'd0);
    chk("midrst_ready", 32'(ready), 32'd1);
    chk("midrst_frame_done", 32'(frame_done), 32'd0);
    chk("midrst_data_out", data_out, 32'd0);
    rst = 1'b0;
    idle(1);
    clear_q();
    for (int p = 9; p <= 16; p++) send(32'(p), 1'b0);
    wait_beats("R", 32);
    check_frame("R", 9);

    // Default-size checkerboard frame.
    big_en = 1'b1;
    for (int i = 0; i < 20000 && b_dat.size() < 7744; i++) @(negedge clk);
    idle(3);
    big_en = 1'b0;
    chk("big_beat_count", 32'(b_dat.size()), 32'd7744);
    bad = 0;
    nd  = 0;
    for (int k = 0; k < b_dat.size() && k < 7744; k++) begin
      if (b_dat[k] !== (((((k / 88) / 2) + ((k % 88) / 2)) % 2 == 1) ? 32'hFFFFFFFF : 32'h00000000))
        bad++;
      if (b_done[k]) nd++;
    end
    chk("big_data_errors", 32'(bad), 32'd0);
    chk("big_done_count", 32'(nd), 32'd1);
    if (b_dat.size() >= 7744) chk("big_done_last", 32'(b_done[7743]), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
